// File: rtl/aes_share_arbiter_if.sv
// Bundles both requester channels and the AES_core operand/result wires shared by the arbiter.
// slave is the arbiter side; master is the side that drives requests and hosts the core.
interface aes_share_arbiter_if;
    logic         iReq0Valid;
    logic         oReq0Ready;
    logic [127:0] iReq0Plaintext;
    logic [127:0] iReq0Key;
    logic         oRsp0Valid;
    logic         iRsp0Ready;
    logic [127:0] oRsp0Data;
    logic         oRsp0Err;

    logic         iReq1Valid;
    logic         oReq1Ready;
    logic [127:0] iReq1Plaintext;
    logic [127:0] iReq1Key;
    logic         oRsp1Valid;
    logic         iRsp1Ready;
    logic [127:0] oRsp1Data;
    logic         oRsp1Err;

    logic         oAesStart;
    logic [127:0] oAesPlaintext;
    logic [127:0] oAesKey;
    logic [127:0] iAesCiphertext;
    logic         iAesDone;
    logic         oBusy;
    logic         oOwner;

    modport slave (
        input  iReq0Valid, iReq0Plaintext, iReq0Key, iRsp0Ready,
        input  iReq1Valid, iReq1Plaintext, iReq1Key, iRsp1Ready,
        input  iAesCiphertext, iAesDone,
        output oReq0Ready, oRsp0Valid, oRsp0Data, oRsp0Err,
        output oReq1Ready, oRsp1Valid, oRsp1Data, oRsp1Err,
        output oAesStart, oAesPlaintext, oAesKey, oBusy, oOwner
    );

    modport master (
        output iReq0Valid, iReq0Plaintext, iReq0Key, iRsp0Ready,
        output iReq1Valid, iReq1Plaintext, iReq1Key, iRsp1Ready,
        output iAesCiphertext, iAesDone,
        input  oReq0Ready, oRsp0Valid, oRsp0Data, oRsp0Err,
        input  oReq1Ready, oRsp1Valid, oRsp1Data, oRsp1Err,
        input  oAesStart, oAesPlaintext, oAesKey, oBusy, oOwner
    );
endinterface

// File: rtl/aes_share_arbiter.sv
// Round-robin sharing of one AES_core between two requesters, with a single
// outstanding operation, edge-detected completion and a watchdog timeout.
module aes_share_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd64
) (
    input  logic                iClk,
    input  logic                iRst,
    aes_share_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    state_t         state_r;
    logic           prio_r;
    logic           owner_r;
    logic           done_q_r;
    logic [15:0]    cnt_r;
    logic [127:0]   op_pt_r;
    logic [127:0]   op_key_r;
    logic           start_r;
    logic           busy_r;
    logic           rsp0_valid_r;
    logic           rsp1_valid_r;
    logic [127:0]   rsp0_data_r;
    logic [127:0]   rsp1_data_r;
    logic           rsp0_err_r;
    logic           rsp1_err_r;

    logic           sel_valid_s;
    logic           sel_idx_s;
    logic           done_edge_s;
    logic           timeout_s;
    logic           rsp_fire_s;

    // Pick a requester: a lone valid wins, a tie goes to prio.
    always_comb begin
        sel_valid_s = bus.iReq0Valid | bus.iReq1Valid;
        sel_idx_s   = 1'b0;
        if (bus.iReq0Valid && bus.iReq1Valid) begin
            sel_idx_s = prio_r;
        end else if (bus.iReq1Valid) begin
            sel_idx_s = 1'b1;
        end else begin
            sel_idx_s = 1'b0;
        end
    end

    // A done level left over from an earlier operation must not count, so only rising edges complete.
    assign done_edge_s = bus.iAesDone && !done_q_r;
    assign timeout_s   = (cnt_r == CNT_LAST);
    assign rsp_fire_s  = owner_r ? (rsp1_valid_r && bus.iRsp1Ready)
                                 : (rsp0_valid_r && bus.iRsp0Ready);

    // Ready is held low while reset is asserted even though the state already reads IDLE.
    assign bus.oReq0Ready = !iRst && (state_r == ST_IDLE) && sel_valid_s && !sel_idx_s;
    assign bus.oReq1Ready = !iRst && (state_r == ST_IDLE) && sel_valid_s &&  sel_idx_s;

    assign bus.oAesStart     = start_r;
    assign bus.oAesPlaintext = op_pt_r;
    assign bus.oAesKey       = op_key_r;
    assign bus.oBusy         = busy_r;
    assign bus.oOwner        = owner_r;
    assign bus.oRsp0Valid    = rsp0_valid_r;
    assign bus.oRsp0Data     = rsp0_data_r;
    assign bus.oRsp0Err      = rsp0_err_r;
    assign bus.oRsp1Valid    = rsp1_valid_r;
    assign bus.oRsp1Data     = rsp1_data_r;
    assign bus.oRsp1Err      = rsp1_err_r;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_r      <= ST_IDLE;
            prio_r       <= 1'b0;
            owner_r      <= 1'b0;
            done_q_r     <= 1'b0;
            cnt_r        <= 16'd0;
            op_pt_r      <= 128'd0;
            op_key_r     <= 128'd0;
            start_r      <= 1'b0;
            busy_r       <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp0_data_r  <= 128'd0;
            rsp1_data_r  <= 128'd0;
            rsp0_err_r   <= 1'b0;
            rsp1_err_r   <= 1'b0;
        end else begin
            done_q_r <= bus.iAesDone;
            case (state_r)
                ST_IDLE: begin
                    if (sel_valid_s) begin
                        owner_r  <= sel_idx_s;
                        op_pt_r  <= sel_idx_s ? bus.iReq1Plaintext : bus.iReq0Plaintext;
                        op_key_r <= sel_idx_s ? bus.iReq1Key       : bus.iReq0Key;
                        start_r  <= 1'b1;
                        busy_r   <= 1'b1;
                        state_r  <= ST_START;
                    end
                end
                ST_START: begin
                    start_r <= 1'b0;
                    cnt_r   <= 16'd0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Done edge is tested first so it beats a simultaneous timeout.
                    if (done_edge_s || timeout_s) begin
                        state_r <= ST_RESP;
                        if (owner_r) begin
                            rsp1_valid_r <= 1'b1;
                            rsp1_data_r  <= done_edge_s ? bus.iAesCiphertext : 128'd0;
                            rsp1_err_r   <= !done_edge_s;
                        end else begin
                            rsp0_valid_r <= 1'b1;
                            rsp0_data_r  <= done_edge_s ? bus.iAesCiphertext : 128'd0;
                            rsp0_err_r   <= !done_edge_s;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_fire_s) begin
                        rsp0_valid_r <= 1'b0;
                        rsp1_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        prio_r       <= ~owner_r;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    start_r      <= 1'b0;
                    busy_r       <= 1'b0;
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
